// File: rtl/dff_bank_pkg.sv
// rtl/dff_bank_pkg.sv - shared constants for the arbitrated flip-flop bank
package dff_bank_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    typedef logic [1:0] opcode_t;

    localparam opcode_t OP_LOAD   = 2'b00;
    localparam opcode_t OP_SET    = 2'b01;
    localparam opcode_t OP_CLEAR  = 2'b10;
    localparam opcode_t OP_TOGGLE = 2'b11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE     = 2'd0;
    localparam state_t ST_APPLY    = 2'd1;
    localparam state_t ST_WAIT_REL = 2'd2;

endpackage

// File: rtl/dff_bank_arbiter_if.sv
// rtl/dff_bank_arbiter_if.sv - requester-side bus of the bank arbiter
interface dff_bank_arbiter_if
    import dff_bank_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) ();

    logic [N_REQ-1:0]       req;
    logic [2*N_REQ-1:0]     op;
    logic [N_REQ*WIDTH-1:0] wdata;
    logic [N_REQ-1:0]       gnt;
    logic [WIDTH-1:0]       q;
    logic                   busy;
    logic                   upd;

    modport master (
        output req, op, wdata,
        input  gnt, q, busy, upd
    );

    modport slave (
        input  req, op, wdata,
        output gnt, q, busy, upd
    );

endinterface

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin selector starting the scan at ptr
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int WIN_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [WIN_W-1:0] ptr,
    output logic [WIN_W-1:0] win,
    output logic             valid
);

    localparam logic [WIN_W:0] N_W = (WIN_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [WIN_W:0]     sum;

    always_comb begin
        // rotate so bit 0 is the requester at ptr; lowest set bit is the winner
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        valid = |rot;
        sum   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sum = {1'b0, ptr} + (WIN_W+1)'(k);
            end
        end
        if (sum >= N_W) begin
            sum = sum - N_W;
        end
        win = sum[WIN_W-1:0];
    end

endmodule

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin arbiter applying one op per handshake to a flop bank
module dff_bank_arbiter
    import dff_bank_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    dff_bank_arbiter_if.slave bus
);

    localparam int              WIN_W = $clog2(N_REQ);
    localparam logic [WIN_W-1:0] LAST = WIN_W'(N_REQ - 1);

    state_t           state;
    logic [WIN_W-1:0] win;
    logic [WIN_W-1:0] ptr;
    logic [WIN_W-1:0] pick;
    logic             pick_valid;
    logic [N_REQ-1:0] gnt;
    logic [WIDTH-1:0] q;
    logic             upd;
    opcode_t          op_sel;
    logic [WIDTH-1:0] data_sel;
    logic             req_win;

    rr_picker #(
        .N_REQ (N_REQ),
        .WIN_W (WIN_W)
    ) u_picker (
        .req   (bus.req),
        .ptr   (ptr),
        .win   (pick),
        .valid (pick_valid)
    );

    always_comb begin
        op_sel   = OP_LOAD;
        data_sel = '0;
        req_win  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win == WIN_W'(i)) begin
                op_sel   = bus.op[2*i +: 2];
                data_sel = bus.wdata[WIDTH*i +: WIDTH];
                req_win  = bus.req[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            win   <= '0;
            ptr   <= '0;
            gnt   <= '0;
            q     <= '0;
            upd   <= 1'b0;
        end else begin
            upd <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        win   <= pick;
                        gnt   <= N_REQ'(1) << pick;
                        state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    // committed at arbitration: applied even if req already dropped
                    case (op_sel)
                        OP_LOAD:  q <= data_sel;
                        OP_SET:   q <= '1;
                        OP_CLEAR: q <= '0;
                        default:  q <= ~q;
                    endcase
                    upd   <= 1'b1;
                    ptr   <= (win == LAST) ? '0 : win + WIN_W'(1);
                    state <= ST_WAIT_REL;
                end
                ST_WAIT_REL: begin
                    if (!req_win) begin
                        gnt   <= '0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt  = gnt;
    assign bus.q    = q;
    assign bus.upd  = upd;
    assign bus.busy = (state != ST_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - self-checking bench for dff_bank_arbiter with a transaction-level model
module tb_dff_bank_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dff_bank_arbiter_if #(.N_REQ(4), .WIDTH(8))  a_if ();
    dff_bank_arbiter_if #(.N_REQ(2), .WIDTH(16)) b_if ();

    dff_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    dff_bank_arbiter #(.N_REQ(2), .WIDTH(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] m_q;
    int         m_ptr;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick(input logic [3:0] mask, input int ptr);
        for (int k = 0; k < 4; k++) begin
            if (mask[(ptr + k) % 4]) return (ptr + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_apply(input logic [1:0] o, input logic [7:0] cur,
                                               input logic [7:0] d);
        case (o)
            2'b00:   return d;
            2'b01:   return 8'hFF;
            2'b10:   return 8'h00;
            default: return ~cur;
        endcase
    endfunction

    task automatic wait_gnt(output int waited);
        waited = 0;
        for (int t = 0; t < 8; t++) begin
            tick();
            waited++;
            if (a_if.gnt != 0) break;
        end
        check("gnt_seen", 32'(a_if.gnt != 0), 32'd1);
    endtask

    task automatic randomize_ops(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                a_if.op[2*i +: 2]    = 2'($urandom_range(0, 3));
                a_if.wdata[8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    // one full handshake: winner holds req for `hold` cycles after the update, then all drop
    task automatic run_txn(input logic [3:0] mask, input int hold, input bit rnd);
        int         exp_w;
        int         waited;
        logic [1:0] e_op;
        logic [7:0] e_d;
        if (rnd) randomize_ops(mask);
        a_if.req = mask;
        exp_w = model_pick(mask, m_ptr);
        e_op  = a_if.op[2*exp_w +: 2];
        e_d   = a_if.wdata[8*exp_w +: 8];
        wait_gnt(waited);
        check("txn_latency", 32'(waited), 32'd1);
        check("txn_gnt", 32'(a_if.gnt), 32'(1) << exp_w);
        check("txn_busy", 32'(a_if.busy), 32'd1);
        tick();
        m_q   = model_apply(e_op, m_q, e_d);
        m_ptr = (exp_w + 1) % 4;
        check("txn_q", 32'(a_if.q), 32'(m_q));
        check("txn_upd", 32'(a_if.upd), 32'd1);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_q", 32'(a_if.q), 32'(m_q));
            check("hold_upd", 32'(a_if.upd), 32'd0);
            check("hold_gnt", 32'(a_if.gnt), 32'(1) << exp_w);
        end
        a_if.req = 4'b0000;
        tick();
        check("rel_gnt", 32'(a_if.gnt), 32'd0);
        check("rel_busy", 32'(a_if.busy), 32'd0);
    endtask

    // requesters in `mask` stay asserted; each drops on its grant and re-raises after release
    task automatic rr_run(input logic [3:0] mask, input int n);
        int         exp_w;
        int         waited;
        logic [1:0] e_op;
        logic [7:0] e_d;
        randomize_ops(mask);
        a_if.req = mask;
        for (int g = 0; g < n; g++) begin
            exp_w = model_pick(a_if.req, m_ptr);
            e_op  = a_if.op[2*exp_w +: 2];
            e_d   = a_if.wdata[8*exp_w +: 8];
            wait_gnt(waited);
            check("rr_latency", 32'(waited), 32'd1);
            check("rr_gnt", 32'(a_if.gnt), 32'(1) << exp_w);
            a_if.req[exp_w] = 1'b0;
            tick();
            m_q   = model_apply(e_op, m_q, e_d);
            m_ptr = (exp_w + 1) % 4;
            check("rr_q", 32'(a_if.q), 32'(m_q));
            check("rr_upd", 32'(a_if.upd), 32'd1);
            tick();
            check("rr_idle_gnt", 32'(a_if.gnt), 32'd0);
            randomize_ops(4'b0001 << exp_w);
            a_if.req[exp_w] = 1'b1;
        end
        a_if.req = 4'b0000;
        tick();
        tick();
        check("rr_end_busy", 32'(a_if.busy), 32'd0);
    endtask

    initial begin
        int order [5];
        rst     = 1'b1;
        a_if.req   = '0;
        a_if.op    = '0;
        a_if.wdata = '0;
        b_if.req   = '0;
        b_if.op    = '0;
        b_if.wdata = '0;
        m_q   = 8'h00;
        m_ptr = 0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_q", 32'(a_if.q), 32'd0);
        check("rst_gnt", 32'(a_if.gnt), 32'd0);
        check("rst_busy", 32'(a_if.busy), 32'd0);
        check("rst_upd", 32'(a_if.upd), 32'd0);
        check("rst_b_q", 32'(b_if.q), 32'd0);

        // single LOAD from requester 2
        a_if.op[5:4]     = 2'b00;
        a_if.wdata[23:16] = 8'hA5;
        run_txn(4'b0100, 0, 1'b0);
        check("load_a5", 32'(a_if.q), 32'hA5);

        // op coverage with long holds; each op must land exactly once
        a_if.op[1:0] = 2'b00; a_if.wdata[7:0] = 8'h3C;
        run_txn(4'b0001, 2, 1'b0);
        a_if.op[3:2] = 2'b01;
        run_txn(4'b0010, 10, 1'b0);
        check("set_ff", 32'(a_if.q), 32'hFF);
        a_if.op[5:4] = 2'b00; a_if.wdata[23:16] = 8'h3C;
        run_txn(4'b0100, 1, 1'b0);
        a_if.op[7:6] = 2'b10;
        run_txn(4'b1000, 10, 1'b0);
        check("clear_00", 32'(a_if.q), 32'h00);
        a_if.op[1:0] = 2'b00; a_if.wdata[7:0] = 8'h3C;
        run_txn(4'b0001, 0, 1'b0);
        a_if.op[3:2] = 2'b11;
        run_txn(4'b0010, 10, 1'b0);
        check("toggle_c3", 32'(a_if.q), 32'hC3);

        // reset while holding in WAIT_REL with q = 5A
        a_if.op[7:6] = 2'b00; a_if.wdata[31:24] = 8'h5A;
        a_if.req = 4'b1000;
        tick();
        tick();
        check("pre_rst_q", 32'(a_if.q), 32'h5A);
        rst = 1'b1;
        #1;
        check("midrst_q", 32'(a_if.q), 32'd0);
        check("midrst_gnt", 32'(a_if.gnt), 32'd0);
        check("midrst_busy", 32'(a_if.busy), 32'd0);
        tick();
        rst = 1'b0;
        a_if.req = 4'b0000;
        m_q   = 8'h00;
        m_ptr = 0;
        tick();

        // strict round-robin from reset: 0,1,2,3,0
        order = '{0, 1, 2, 3, 0};
        a_if.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            int waited;
            wait_gnt(waited);
            check("rr_order", 32'(a_if.gnt), 32'(1) << order[g]);
            m_q = model_apply(a_if.op[2*order[g] +: 2], m_q, a_if.wdata[8*order[g] +: 8]);
            a_if.req[order[g]] = 1'b0;
            tick();
            check("rr_order_q", 32'(a_if.q), 32'(m_q));
            tick();
            a_if.req[order[g]] = 1'b1;
        end
        m_ptr = 1;
        a_if.req = 4'b0000;
        tick();
        tick();
        rr_run(4'b1111, 6);
        rr_run(4'b1001, 4);

        // early drop: one-cycle pulse on requester 1 with SET
        a_if.op[3:2] = 2'b01;
        a_if.req = 4'b0010;
        tick();
        a_if.req = 4'b0000;
        check("early_gnt", 32'(a_if.gnt), 32'b0010);
        tick();
        check("early_q", 32'(a_if.q), 32'hFF);
        check("early_busy2", 32'(a_if.busy), 32'd1);
        tick();
        check("early_busy3", 32'(a_if.busy), 32'd0);
        check("early_gnt3", 32'(a_if.gnt), 32'd0);
        m_q   = 8'hFF;
        m_ptr = 2;

        // randomized contention
        for (int r = 0; r < 30; r++) begin
            run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'b1);
        end

        // second configuration: N_REQ=2, WIDTH=16
        b_if.op    = 4'b0000;
        b_if.wdata[31:16] = 16'hBEEF;
        b_if.req   = 2'b10;
        tick();
        check("b_gnt1", 32'(b_if.gnt), 32'b10);
        tick();
        check("b_q_beef", 32'(b_if.q), 32'hBEEF);
        check("b_upd", 32'(b_if.upd), 32'd1);
        b_if.req = 2'b00;
        tick();
        check("b_rel", 32'(b_if.gnt), 32'd0);
        b_if.op  = 4'b0011;
        b_if.req = 2'b11;
        tick();
        check("b_rr_gnt0", 32'(b_if.gnt), 32'b01);
        b_if.req[0] = 1'b0;
        tick();
        check("b_toggle", 32'(b_if.q), 32'h4110);
        tick();
        check("b_idle", 32'(b_if.gnt), 32'd0);
        tick();
        check("b_rr_gnt1", 32'(b_if.gnt), 32'b10);
        tick();
        check("b_reload", 32'(b_if.q), 32'hBEEF);
        b_if.req = 2'b00;
        tick();
        tick();
        check("b_end_busy", 32'(b_if.busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Shared-register controller that arbitrates write access from N_REQ requesters to one WIDTH-bit flip-flop bank. Round-robin arbitration with a 4-phase req/gnt handshake; each granted transaction applies exactly one operation (load, set-all, clear-all, toggle) to the bank. Sits between independent control agents and the storage flops, so only this block ever drives the bank's load/set/clear controls.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, bank width in bits
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester request, level, held until gnt seen
- op  input  2*N_REQ  per-requester opcode, op[2i+1:2i] for requester i
- wdata  input  N_REQ*WIDTH  per-requester load data, slice i at [WIDTH*i +: WIDTH]
- gnt  output  N_REQ  one-hot grant, all-zero when idle
- q  output  WIDTH  bank contents
- busy  output  1  high whenever state != IDLE
- upd  output  1  one-cycle pulse, high in the cycle q first shows a new applied op

## Operation
- Opcodes: 00 LOAD (q <= wdata[win]), 01 SET (all ones), 10 CLEAR (all zeros), 11 TOGGLE (q <= ~q).
- States: IDLE, APPLY, WAIT_REL.
- IDLE: gnt=0. If any req bit high, pick winner = first asserted index scanning ptr, ptr+1, ... mod N_REQ; register win; go APPLY. No req: stay.
- APPLY (exactly 1 cycle): gnt[win]=1; op[win]/wdata[win] sampled this cycle; at its closing edge q updated, ptr <= (win+1) mod N_REQ, go WAIT_REL.
- WAIT_REL: gnt[win]=1; when req[win] sampled 0, go IDLE. Other requests ignored until then.
- Request dropped during APPLY: op still applied (committed at arbitration); WAIT_REL exits on first cycle.
- Exactly one op per handshake; holding req high never repeats the op.
- Unlisted N_REQ indices never granted; win width = clog2(N_REQ).

## Timing
- Reset (async assert, sync release): state=IDLE, q=0, gnt=0, busy=0, upd=0, ptr=0, win=0. Takes effect immediately, mid-transaction included; an op whose APPLY edge coincides with reset assertion is discarded.
- req seen in IDLE at cycle 0 -> gnt high cycle 1 -> new q visible cycle 2 with upd=1 in cycle 2.
- gnt falls in the cycle after req[win] is sampled low; earliest back-to-back grant to another requester: 1 IDLE cycle between grants (next gnt 2 cycles after req drop).
- Minimum transaction: 3 cycles (IDLE, APPLY, WAIT_REL) when requester drops req during APPLY.
- Simultaneous requests: strict round-robin; after reset requester 0 has highest priority.
- busy combinational from state register; gnt and upd are registered-state decodes, glitch-free.
- No combinational path from req/op/wdata to any output.

## Structure
- Package dff_bank_pkg: opcode constants (OP_LOAD, OP_SET, OP_CLEAR, OP_TOGGLE), state enum encoding, default parameter values.
- Sub-module rr_picker: combinational round-robin selector (req, ptr -> win, valid), instantiated once; FSM and bank flops stay in the top.

## Test plan
- Reset: drive req=0; after rst release q=0, gnt=0, busy=0; assert rst during WAIT_REL with q=8'h5A -> q=0, gnt=0 same cycle.
- Single LOAD: req[2]=1, op=00, wdata=8'hA5 -> gnt=4'b0100 next cycle, q=8'hA5 and upd=1 the cycle after; drop req -> gnt=0 one cycle later.
- Op coverage from q=8'h3C: SET -> 8'hFF, CLEAR -> 8'h00, TOGGLE on 8'h3C -> 8'hC3; each req held 10 cycles -> op applied once only.
- Round-robin: req=4'b1111 continuously, each requester drops on gnt -> grant order 0,1,2,3,0; then req=4'b1001 after granting 3 -> 0 granted next.
- Early drop: req[1] pulsed one cycle with op=01 -> still granted, q=8'hFF, WAIT_REL exits in one cycle, busy low 3 cycles after req.
- Parameter sweep N_REQ=2, WIDTH=16: LOAD 16'hBEEF from requester 1 -> q=16'hBEEF; gnt bits beyond N_REQ never asserted.
